// File: rtl/fifo_prog.sv
// fifo_prog: circular FWFT FIFO with programmable almost-full/almost-empty flags.
// Optional sticky overflow/underflow flags when FIFO_PROG_ERR_FLAGS_EN is defined.
module fifo_prog #(
   parameter  int DATA_WIDTH = 32,
   parameter  int FIFO_DEPTH = 64,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  drop,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic [CW-1:0]         awaiting_count,
   input  logic [CW-1:0]         afull_th,
   input  logic [CW-1:0]         aempty_th,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic                  acc_push;
   logic                  acc_drop;

   assign awaiting_count = count;
   assign fifo_empty     = (count == '0);
   assign fifo_full      = (count == CW'(FIFO_DEPTH));
   assign almost_full    = (count >= afull_th);
   assign almost_empty   = (count <= aempty_th);
   assign data_o         = mem[rd_ptr];

   // a full FIFO still takes a push when the head leaves in the same cycle
   assign acc_drop = drop & ~fifo_empty;
   assign acc_push = push & (~fifo_full | drop);

   // pointer and occupancy tracking; flush overrides push and drop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (acc_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (acc_drop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(acc_push) - CW'(acc_drop);
      end
   end

   // storage array, intentionally left unreset
   always_ff @(posedge clk) begin
      if (acc_push && !flush)
         mem[wr_ptr] <= data_i;
   end

`ifdef FIFO_PROG_ERR_FLAGS_EN
   logic ov_ev;
   logic ud_ev;

   assign ov_ev = push & fifo_full & ~drop & ~flush;
   assign ud_ev = drop & fifo_empty & ~flush;

   // sticky error flags; a new event beats a clear in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ov_ev)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (ud_ev)
            underflow <= 1'b1;
         else if (err_clr)
            underflow <= 1'b0;
      end
   end
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog: directed and randomized checks of fifo_prog (depth 4)
// against a queue-based reference model.
module tb_fifo_prog;

   localparam int DW = 16;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;
`ifdef FIFO_PROG_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic          push = 1'b0;
   logic [DW-1:0] data_o;
   logic          drop = 1'b0;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] awaiting_count;
   logic [CW-1:0] afull_th = '0;
   logic [CW-1:0] aempty_th = '0;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow;
   logic          underflow;
   logic          err_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] q[$];
   bit            m_ovf = 0;
   bit            m_udf = 0;

   fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush), .data_i(data_i),
      .push(push), .data_o(data_o), .drop(drop),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .awaiting_count(awaiting_count), .afull_th(afull_th),
      .aempty_th(aempty_th), .almost_full(almost_full),
      .almost_empty(almost_empty), .overflow(overflow),
      .underflow(underflow), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      bit full_n;
      bit empty_n;
      bit ov_ev;
      bit ud_ev;
      if (rst) begin
         q.delete();
         m_ovf = 0;
         m_udf = 0;
         return;
      end
      full_n  = (q.size() == D);
      empty_n = (q.size() == 0);
      ov_ev = push && full_n && !drop && !flush;
      ud_ev = drop && empty_n && !flush;
      if (ERR_EN) begin
         if (ov_ev) m_ovf = 1;
         else if (err_clr) m_ovf = 0;
         if (ud_ev) m_udf = 1;
         else if (err_clr) m_udf = 0;
      end
      if (flush) begin
         q.delete();
      end else begin
         if (drop && !empty_n)
            void'(q.pop_front());
         if (push && (!full_n || drop))
            q.push_back(data_i);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      push = 0; drop = 0; flush = 0; err_clr = 0;
   endtask

   task automatic test_reset();
      rst = 1; afull_th = '0; aempty_th = 3'd2;
      idle();
      tick();
      rst = 0;
      #1;
      n_tests++;
      if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
          awaiting_count !== '0) begin
         n_fail++;
         $display("FAIL reset_state: empty=%b full=%b cnt=%0d need 1 0 0",
                  fifo_empty, fifo_full, awaiting_count);
      end
      n_tests++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: ovf=%b udf=%b need 0 0",
                  overflow, underflow);
      end
      n_tests++;
      if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_almost: af=%b ae=%b need 1 1",
                  almost_full, almost_empty);
      end
   endtask

   task automatic test_fill();
      logic [DW-1:0] v;
      afull_th = 3'd3; aempty_th = '0;
      for (int i = 0; i < D; i++) begin
         v = DW'(16'hA000 + i);
         push = 1; data_i = v;
         tick();
         n_tests++;
         if (awaiting_count !== CW'(i + 1) ||
             almost_full !== (i + 1 >= 3)) begin
            n_fail++;
            $display("FAIL fill_cnt%0d: cnt=%0d af=%b need %0d %b",
                     i, awaiting_count, almost_full, i + 1, (i + 1 >= 3));
         end
      end
      idle();
      n_tests++;
      if (fifo_full !== 1'b1 || data_o !== 16'hA000) begin
         n_fail++;
         $display("FAIL fill_full: full=%b data=%h need 1 a000",
                  fifo_full, data_o);
      end
   endtask

   task automatic test_push_drop_full();
      logic [DW-1:0] exp [4];
      exp[0] = 16'hA001; exp[1] = 16'hA002;
      exp[2] = 16'hA003; exp[3] = 16'hE000;
      push = 1; drop = 1; data_i = 16'hE000;
      tick();
      idle();
      n_tests++;
      if (awaiting_count !== CW'(4) || data_o !== 16'hA001) begin
         n_fail++;
         $display("FAIL full_pushdrop: cnt=%0d data=%h need 4 a001",
                  awaiting_count, data_o);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (data_o !== exp[i]) begin
            n_fail++;
            $display("FAIL drain%0d: data=%h need %h", i, data_o, exp[i]);
         end
         drop = 1;
         tick();
      end
      idle();
      n_tests++;
      if (fifo_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_empty: empty=%b need 1", fifo_empty);
      end
   endtask

   task automatic test_empty_push_drop();
      push = 1; drop = 1; data_i = 16'h5A5A;
      tick();
      idle();
      n_tests++;
      if (awaiting_count !== CW'(1) || data_o !== 16'h5A5A) begin
         n_fail++;
         $display("FAIL empty_pushdrop: cnt=%0d data=%h need 1 5a5a",
                  awaiting_count, data_o);
      end
      n_tests++;
      if (underflow !== ERR_EN) begin
         n_fail++;
         $display("FAIL underflow_set: udf=%b need %b", underflow, ERR_EN);
      end
      drop = 1; err_clr = 1;
      tick();
      idle();
      n_tests++;
      if (underflow !== 1'b0 || fifo_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow_clr: udf=%b empty=%b need 0 1",
                  underflow, fifo_empty);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < D; i++) begin
         push = 1; data_i = DW'(16'hC000 + i);
         tick();
      end
      push = 1; data_i = 16'hDEAD;
      tick();
      tick();
      idle();
      n_tests++;
      if (awaiting_count !== CW'(4) || data_o !== 16'hC000 ||
          overflow !== ERR_EN) begin
         n_fail++;
         $display("FAIL overflow: cnt=%0d data=%h ovf=%b need 4 c000 %b",
                  awaiting_count, data_o, overflow, ERR_EN);
      end
      err_clr = 1;
      tick();
      idle();
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clr: ovf=%b need 0", overflow);
      end
   endtask

   task automatic test_almost_empty();
      drop = 1;
      tick();
      idle();
      aempty_th = 3'd1;
      #1;
      n_tests++;
      if (awaiting_count !== CW'(3) || almost_empty !== 1'b0 ||
          data_o !== 16'hC001) begin
         n_fail++;
         $display("FAIL ae_start: cnt=%0d ae=%b data=%h need 3 0 c001",
                  awaiting_count, almost_empty, data_o);
      end
      for (int i = 2; i >= 0; i--) begin
         drop = 1;
         tick();
         n_tests++;
         if (awaiting_count !== CW'(i) || almost_empty !== (i <= 1) ||
             fifo_empty !== (i == 0)) begin
            n_fail++;
            $display("FAIL ae_cnt%0d: cnt=%0d ae=%b empty=%b", i,
                     awaiting_count, almost_empty, fifo_empty);
         end
      end
      idle();
   endtask

   task automatic test_flush();
      for (int i = 0; i < D; i++) begin
         push = 1; data_i = DW'(16'hF000 + i);
         tick();
      end
      push = 1; data_i = 16'hBAD0;
      tick();
      push = 0; drop = 1;
      tick();
      idle();
      flush = 1; push = 1; data_i = 16'hBAD1;
      tick();
      idle();
      n_tests++;
      if (awaiting_count !== '0 || fifo_empty !== 1'b1 ||
          overflow !== ERR_EN) begin
         n_fail++;
         $display("FAIL flush: cnt=%0d empty=%b ovf=%b need 0 1 %b",
                  awaiting_count, fifo_empty, overflow, ERR_EN);
      end
      push = 1; data_i = 16'h1234;
      tick();
      idle();
      n_tests++;
      if (awaiting_count !== CW'(1) || data_o !== 16'h1234) begin
         n_fail++;
         $display("FAIL post_flush: cnt=%0d data=%h need 1 1234",
                  awaiting_count, data_o);
      end
   endtask

   task automatic test_async_reset();
      push = 1; data_i = 16'h7777;
      tick();
      tick();
      push = 0; flush = 0;
      #1;
      rst = 1;
      #1;
      q.delete(); m_ovf = 0; m_udf = 0;
      n_tests++;
      if (awaiting_count !== '0 || fifo_empty !== 1'b1 ||
          fifo_full !== 1'b0 || overflow !== 1'b0 ||
          underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst: cnt=%0d e=%b f=%b o=%b u=%b",
                  awaiting_count, fifo_empty, fifo_full,
                  overflow, underflow);
      end
      #1;
      rst = 0;
      idle();
   endtask

   task automatic test_random();
      int sz;
      int bad;
      for (int c = 0; c < 600; c++) begin
         push    = ($urandom_range(0, 9) < 6);
         drop    = ($urandom_range(0, 9) < 5);
         flush   = ($urandom_range(0, 49) == 0);
         err_clr = ($urandom_range(0, 19) == 0);
         data_i  = DW'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            afull_th  = CW'($urandom_range(0, 7));
            aempty_th = CW'($urandom_range(0, 7));
         end
         tick();
         #1;
         sz = q.size();
         bad = 0;
         if (awaiting_count !== CW'(sz)) bad = 1;
         if (fifo_empty !== (sz == 0)) bad = 1;
         if (fifo_full !== (sz == D)) bad = 1;
         if (almost_full !== (sz >= int'(afull_th))) bad = 1;
         if (almost_empty !== (sz <= int'(aempty_th))) bad = 1;
         if (overflow !== m_ovf || underflow !== m_udf) bad = 1;
         if (sz != 0 && data_o !== q[0]) bad = 1;
         n_tests++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL rand%0d: cnt=%0d/%0d e=%b f=%b af=%b ae=%b o=%b/%b u=%b/%b d=%h/%h",
                     c, awaiting_count, sz, fifo_empty, fifo_full,
                     almost_full, almost_empty, overflow, m_ovf,
                     underflow, m_udf, data_o,
                     (sz != 0) ? q[0] : '0);
         end
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill();
      test_push_drop_full();
      test_empty_push_drop();
      test_overflow();
      test_almost_empty();
      test_flush();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
